// File: rtl/t2mi_pkg.sv
// ---------------------------------------------------------------------------
// t2mi_pkg
// Shared constants and types for the T2-MI receive path.
//   TS_PKT_LEN      : transport stream packet length in bytes
//   TS_SYNC_BYTE    : sync byte expected at packet offset 0
//   aligner_state_t : ts_sync_aligner framing states
//   offset_next()   : packet offset increment with wrap at the last offset
// ---------------------------------------------------------------------------
package t2mi_pkg;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } aligner_state_t;

    function automatic logic [7:0] offset_next(input logic [7:0] ofs,
                                               input logic [7:0] last_ofs);
        return (ofs == last_ofs) ? 8'd0 : ofs + 8'd1;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter with synchronous clear and selectable overflow mode.
//   clk_100mhz : clock, rising edge
//   clear      : synchronous clear, dominates enable
//   enable     : count one event this cycle
//   saturate   : 1 = stick at 16'hFFFF, 0 = wrap to 0
//   count      : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
    input  logic        clk_100mhz,
    input  logic        clear,
    input  logic        enable,
    input  logic        saturate,
    output logic [15:0] count
);

    always_ff @(posedge clk_100mhz) begin
        if (clear) begin
            count <= 16'd0;
        end else if (enable) begin
            if (!(saturate && (count == 16'hFFFF))) begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// ts_sync_aligner
// Hunts for the TS packet boundary in a raw byte stream, locks after repeated
// sync hits and forwards packet-delimited bytes one clock later.
//   clk_100mhz   : clock, rising edge
//   rst          : synchronous active-high reset
//   in_valid     : in_data valid this cycle (gaps allowed anywhere)
//   in_data      : stream byte
//   out_valid    : aligned byte valid (locked only)
//   out_data     : aligned byte
//   out_sop      : byte is packet offset 0
//   out_eop      : byte is packet offset PKT_LEN-1
//   out_sync_err : with out_sop, sync byte of this packet was wrong (flywheel)
//   locked       : aligner is locked
//   lock_lost    : one-cycle pulse on loss of lock
//   pkt_count    : aligned packets started, wrapping
//   miss_count   : sync misses while locked, saturating
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HUNT   | searching byte by byte for a sync candidate
// ST_VERIFY | candidate found, checking sync at each packet boundary
// ST_LOCKED | aligned; bytes forwarded, misses flywheeled until too many
// ---------------------------------------------------------------------------
module ts_sync_aligner
    import t2mi_pkg::*;
#(
    parameter int unsigned PKT_LEN      = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE    = TS_SYNC_BYTE,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 3
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_sync_err,
    output logic        locked,
    output logic        lock_lost,
    output logic [15:0] pkt_count,
    output logic [15:0] miss_count
);

    localparam logic [7:0] LAST_OFS = 8'(PKT_LEN - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    aligner_state_t state, state_nxt;
    logic [7:0]     byte_cnt, byte_cnt_nxt;
    logic [3:0]     hit_cnt, hit_cnt_nxt;
    logic [3:0]     miss_cnt, miss_cnt_nxt;

    logic emit_nxt, sop_nxt, eop_nxt, sync_err_nxt, lock_lost_nxt;
    logic pkt_inc, miss_inc;
    logic is_sync, is_check;

    assign is_sync  = (in_data == SYNC_BYTE);
    assign is_check = (byte_cnt == 8'd0);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state        <= ST_HUNT;
            byte_cnt     <= 8'd0;
            hit_cnt      <= 4'd0;
            miss_cnt     <= 4'd0;
            out_valid    <= 1'b0;
            out_data     <= 8'd0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_sync_err <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            hit_cnt      <= hit_cnt_nxt;
            miss_cnt     <= miss_cnt_nxt;
            out_valid    <= emit_nxt;
            out_sop      <= sop_nxt;
            out_eop      <= eop_nxt;
            out_sync_err <= sync_err_nxt;
            lock_lost    <= lock_lost_nxt;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        hit_cnt_nxt   = hit_cnt;
        miss_cnt_nxt  = miss_cnt;
        emit_nxt      = 1'b0;
        sop_nxt       = 1'b0;
        eop_nxt       = 1'b0;
        sync_err_nxt  = 1'b0;
        lock_lost_nxt = 1'b0;
        pkt_inc       = 1'b0;
        miss_inc      = 1'b0;

        if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    if (is_sync) begin
                        state_nxt    = ST_VERIFY;
                        byte_cnt_nxt = offset_next(8'd0, LAST_OFS);
                        hit_cnt_nxt  = 4'd1;
                    end
                end

                ST_VERIFY: begin
                    if (!is_check) begin
                        byte_cnt_nxt = offset_next(byte_cnt, LAST_OFS);
                    end else if (is_sync) begin
                        byte_cnt_nxt = offset_next(byte_cnt, LAST_OFS);
                        hit_cnt_nxt  = hit_cnt + 4'd1;
                        if ((hit_cnt + 4'd1) == LOCK_N) begin
                            state_nxt    = ST_LOCKED;
                            miss_cnt_nxt = 4'd0;
                            emit_nxt     = 1'b1;
                            sop_nxt      = 1'b1;
                            pkt_inc      = 1'b1;
                        end
                    end else begin
                        // Failing check byte is known not to be a sync byte,
                        // so it is simply dropped rather than re-hunted.
                        state_nxt    = ST_HUNT;
                        byte_cnt_nxt = 8'd0;
                        hit_cnt_nxt  = 4'd0;
                    end
                end

                ST_LOCKED: begin
                    if (!is_check) begin
                        byte_cnt_nxt = offset_next(byte_cnt, LAST_OFS);
                        emit_nxt     = 1'b1;
                        eop_nxt      = (byte_cnt == LAST_OFS);
                    end else if (is_sync) begin
                        byte_cnt_nxt = offset_next(byte_cnt, LAST_OFS);
                        miss_cnt_nxt = 4'd0;
                        emit_nxt     = 1'b1;
                        sop_nxt      = 1'b1;
                        pkt_inc      = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                        if ((miss_cnt + 4'd1) < UNLOCK_N) begin
                            // Flywheel: keep framing, flag the bad sync.
                            byte_cnt_nxt = offset_next(byte_cnt, LAST_OFS);
                            miss_cnt_nxt = miss_cnt + 4'd1;
                            emit_nxt     = 1'b1;
                            sop_nxt      = 1'b1;
                            sync_err_nxt = 1'b1;
                            pkt_inc      = 1'b1;
                        end else begin
                            state_nxt     = ST_HUNT;
                            byte_cnt_nxt  = 8'd0;
                            hit_cnt_nxt   = 4'd0;
                            miss_cnt_nxt  = 4'd0;
                            lock_lost_nxt = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt    = ST_HUNT;
                    byte_cnt_nxt = 8'd0;
                    hit_cnt_nxt  = 4'd0;
                    miss_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

    sat_counter16 u_pkt_counter (
        .clk_100mhz (clk_100mhz),
        .clear      (rst),
        .enable     (pkt_inc),
        .saturate   (1'b0),
        .count      (pkt_count)
    );

    sat_counter16 u_miss_counter (
        .clk_100mhz (clk_100mhz),
        .clear      (rst),
        .enable     (miss_inc),
        .saturate   (1'b1),
        .count      (miss_count)
    );

endmodule

// File: tb/tb_ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// tb_ts_sync_aligner
// Drives scripted and randomized TS streams into ts_sync_aligner and compares
// every output, every cycle, against a stream-position reference model.
// ---------------------------------------------------------------------------
module tb_ts_sync_aligner;

    localparam int         PKT_LEN      = 188;
    localparam logic [7:0] SYNC         = 8'h47;
    localparam int         LOCK_COUNT   = 3;
    localparam int         UNLOCK_COUNT = 3;

    logic        clk_100mhz = 1'b0;
    logic        rst        = 1'b1;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_sync_err;
    logic        locked;
    logic        lock_lost;
    logic [15:0] pkt_count;
    logic [15:0] miss_count;

    always #5 clk_100mhz = ~clk_100mhz;

    ts_sync_aligner dut (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_sync_err (out_sync_err),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .pkt_count    (pkt_count),
        .miss_count   (miss_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: framing tracked as the stream position of the sync
    // candidate; packet offset is the distance from it modulo PKT_LEN.
    int         m_pos, m_anchor, m_hits, m_misses;
    bit         m_locked;
    bit         e_valid, e_sop, e_eop, e_err, e_lost;
    logic [7:0] e_data;
    int         e_pkt, e_miss;

    int         sop_seen, err_seen, lost_seen;
    logic [7:0] cap_q[$];
    bit         gap_mode;

    task automatic model_reset();
        m_pos = 0; m_anchor = -1; m_hits = 0; m_misses = 0; m_locked = 0;
        e_data = 8'h00; e_pkt = 0; e_miss = 0;
    endtask

    task automatic model_emit(input int off, input bit err);
        e_valid = 1;
        e_sop   = (off == 0);
        e_eop   = (off == PKT_LEN - 1);
        e_err   = err;
        if (off == 0) e_pkt = (e_pkt + 1) % 65536;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        int off;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_lost = 0;
        if (r) begin
            model_reset();
        end else if (v) begin
            e_data = d;
            if (m_anchor < 0) begin
                if (d == SYNC) begin
                    m_anchor = m_pos;
                    m_hits   = 1;
                end
            end else begin
                off = (m_pos - m_anchor) % PKT_LEN;
                if (!m_locked) begin
                    if (off == 0) begin
                        if (d == SYNC) begin
                            m_hits++;
                            if (m_hits == LOCK_COUNT) begin
                                m_locked = 1;
                                m_misses = 0;
                                model_emit(0, 0);
                            end
                        end else begin
                            m_anchor = -1;
                            m_hits   = 0;
                        end
                    end
                end else if (off != 0 || d == SYNC) begin
                    if (off == 0) m_misses = 0;
                    model_emit(off, 0);
                end else begin
                    m_misses++;
                    if (e_miss < 65535) e_miss++;
                    if (m_misses < UNLOCK_COUNT) begin
                        model_emit(0, 1);
                    end else begin
                        m_locked = 0; m_anchor = -1; m_hits = 0; m_misses = 0;
                        e_lost = 1;
                    end
                end
            end
            m_pos++;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        rst = r; in_valid = v; in_data = d;
        @(posedge clk_100mhz);
        model_step(r, v, d);
        #1;
        check_val("out_valid",    out_valid,    e_valid);
        check_val("out_sop",      out_sop,      e_sop);
        check_val("out_eop",      out_eop,      e_eop);
        check_val("out_sync_err", out_sync_err, e_err);
        check_val("lock_lost",    lock_lost,    e_lost);
        check_val("locked",       locked,       m_locked);
        check_val("out_data",     out_data,     e_data);
        check_val("pkt_count",    pkt_count,    e_pkt);
        check_val("miss_count",   miss_count,   e_miss);
        if (out_valid) cap_q.push_back(out_data);
        if (out_valid && out_sop) sop_seen++;
        if (out_valid && out_sync_err) err_seen++;
        if (lock_lost) lost_seen++;
    endtask

    function automatic logic [7:0] rand_not_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        if (gap_mode) begin
            repeat ($urandom_range(0, 2))
                step(0, 0, ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom));
        end
        step(0, 1, d);
        if (gap_mode && $urandom_range(0, 3) == 0) step(0, 0, SYNC);
    endtask

    task automatic send_range(input bit good_sync, input int first, input int last);
        for (int off = first; off <= last; off++) begin
            if (off == 0) send_byte(good_sync ? SYNC : rand_not_sync());
            else          send_byte(8'(off));
        end
    endtask

    task automatic send_packets(input int n, input bit good_sync);
        for (int p = 0; p < n; p++) send_range(good_sync, 0, PKT_LEN - 1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, $urandom_range(0, 1), 8'($urandom));
        sop_seen = 0; err_seen = 0; lost_seen = 0;
        cap_q.delete();
    endtask

    initial begin
        model_reset();
        gap_mode = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_lost = 0;

        // Reset state
        do_reset(3);
        check_val("rst_locked", locked, 0);
        check_val("rst_pkt_count", pkt_count, 0);

        // Clean stream: lock on packet 3, three packets forwarded
        send_packets(5, 1);
        step(0, 0, 8'h00);
        check_val("clean_pkt_count", pkt_count, 3);
        check_val("clean_sops", sop_seen, 3);
        check_val("clean_bytes", cap_q.size(), 3 * PKT_LEN);

        // Flywheel over two bad syncs, then recovery
        err_seen = 0;
        send_packets(2, 0);
        send_packets(1, 1);
        check_val("fly_miss_count", miss_count, 2);
        check_val("fly_err_sops", err_seen, 2);
        check_val("fly_locked", locked, 1);

        // Three bad syncs lose lock
        send_packets(3, 0);
        check_val("unlock_pulses", lost_seen, 1);
        check_val("unlock_locked", locked, 0);
        check_val("unlock_miss_count", miss_count, 5);

        // Misaligned start: garbage without sync bytes
        do_reset(1);
        for (int i = 0; i < 57; i++) send_byte(rand_not_sync());
        send_packets(5, 1);
        check_val("misalign_sops", sop_seen, 3);
        check_val("misalign_bytes", cap_q.size(), 3 * PKT_LEN);

        // False sync at garbage offset 20, lock only later
        do_reset(1);
        for (int i = 0; i < 57; i++) send_byte((i == 20) ? SYNC : rand_not_sync());
        send_packets(6, 1);
        check_val("false_sync_sops", sop_seen, 3);
        check_val("false_sync_locked", locked, 1);

        // Gapped input: same forwarded byte sequence as contiguous
        do_reset(1);
        gap_mode = 1;
        send_packets(5, 1);
        gap_mode = 0;
        step(0, 0, SYNC);
        check_val("gap_bytes", cap_q.size(), 3 * PKT_LEN);
        for (int i = 0; i < cap_q.size() && i < 3 * PKT_LEN; i++)
            check_val("gap_byte", cap_q[i], ((i % PKT_LEN) == 0) ? SYNC : 8'(i % PKT_LEN));

        // Reset mid-packet while locked
        send_range(1, 0, 99);
        cap_q.delete();
        sop_seen = 0;
        step(1, 1, 8'd100);
        check_val("midrst_valid", out_valid, 0);
        check_val("midrst_pkt_count", pkt_count, 0);
        check_val("midrst_miss_count", miss_count, 0);
        check_val("midrst_locked", locked, 0);
        send_range(1, 101, PKT_LEN - 1);
        check_val("midrst_no_partial", cap_q.size(), 0);
        send_packets(4, 1);
        check_val("relock_locked", locked, 1);
        check_val("relock_pkt_count", pkt_count, 2);
        check_val("relock_bytes", cap_q.size(), 2 * PKT_LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
